rgmii_tx_sched: RTL and testbench

RGMII_TX_SCHED -- requirements
Module: rgmii_tx_sched

---
 rtl/rgmii_tx_sched.sv | 184 ++++++++++++++++++
 tb/tb_rgmii_tx_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_tx_sched.sv
// rgmii_tx_sched: two-channel RGMII transmit scheduler with round-robin grant, inter-packet gap and burst limit.
// Define TX_TIMEOUT_EN to build the BUSY watchdog; otherwise BUSY waits for tx_done indefinitely.
module rgmii_tx_sched #(
  parameter int unsigned IPG_CYCLES     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ctrl,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        tx_done,
  output logic        grant_a,
  output logic        grant_b,
  output logic        tx_start,
  output logic        rgmii_ctrl,
  output logic [31:0] pkt_cnt,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(IPG_CYCLES - 1);

  state_t      state_q;
  logic [15:0] ctrl_q;
  logic        grant_a_q;
  logic        grant_b_q;
  logic        tx_start_q;
  logic        rgmii_ctrl_q;
  logic        last_b_q;
  logic        burst_done_q;
  logic [7:0]  gap_cnt_q;
  logic [31:0] pkt_cnt_q;
  logic [31:0] pkt_cnt_d;
  logic [8:0]  burst_cnt_q;
  logic [8:0]  burst_cnt_d;
  logic [8:0]  burst_len;

  logic run;
  logic burst_mode;
  logic cnt_clr;
  logic start_ok;
  logic pick_a;
  logic pkt_done;
  logic pkt_abort;
  logic pkt_end;
  logic unused_ok;

  assign run        = ctrl_q[0];
  assign burst_mode = ctrl_q[1];
  assign cnt_clr    = ctrl_q[2];
  assign burst_len  = (ctrl_q[15:8] == 8'd0) ? 9'd256 : {1'b0, ctrl_q[15:8]};

  // A host stop seen in IDLE blocks a new start even while rgmii_ctrl is still falling.
  assign start_ok = (state_q == IDLE) && rgmii_ctrl_q && run && !burst_done_q && (req_a || req_b);
  assign pick_a   = req_a && (!req_b || last_b_q);
  assign pkt_done = (state_q == BUSY) && tx_done;
  assign pkt_end  = pkt_done || pkt_abort;

  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    burst_cnt_d = burst_cnt_q;
    if (cnt_clr) begin
      pkt_cnt_d = 32'd0;
    end else if (pkt_done) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
    if (cnt_clr || !run) begin
      burst_cnt_d = 9'd0;
    end else if (pkt_done) begin
      burst_cnt_d = burst_cnt_q + 9'd1;
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam logic [15:0] WDOG_LOAD = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdog_q;
  logic        timeout_err_q;

  assign pkt_abort = (state_q == BUSY) && !tx_done && (wdog_q == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q        <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == START) begin
        wdog_q <= WDOG_LOAD;
      end else if ((state_q == BUSY) && (wdog_q != 16'd0)) begin
        wdog_q <= wdog_q - 16'd1;
      end
      if (cnt_clr) begin
        timeout_err_q <= 1'b0;
      end else if (pkt_abort) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
  assign unused_ok   = ^ctrl_q[7:3];
`else
  assign pkt_abort   = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_ok   = ^{ctrl_q[7:3], 16'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ctrl_q       <= 16'd0;
      grant_a_q    <= 1'b0;
      grant_b_q    <= 1'b0;
      tx_start_q   <= 1'b0;
      rgmii_ctrl_q <= 1'b0;
      last_b_q     <= 1'b1;
      burst_done_q <= 1'b0;
      gap_cnt_q    <= 8'd0;
      pkt_cnt_q    <= 32'd0;
      burst_cnt_q  <= 9'd0;
    end else begin
      ctrl_q      <= ctrl;
      tx_start_q  <= 1'b0;
      pkt_cnt_q   <= pkt_cnt_d;
      burst_cnt_q <= burst_cnt_d;

      if (!run) begin
        burst_done_q <= 1'b0;
      end else if (burst_mode && (burst_cnt_q >= burst_len)) begin
        burst_done_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          rgmii_ctrl_q <= run && !burst_done_q;
          if (start_ok) begin
            state_q    <= START;
            grant_a_q  <= pick_a;
            grant_b_q  <= !pick_a;
            tx_start_q <= 1'b1;
          end
        end
        START: begin
          state_q <= BUSY;
        end
        BUSY: begin
          if (pkt_end) begin
            state_q   <= GAP;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            last_b_q  <= grant_b_q;
            gap_cnt_q <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt_q == 8'd0) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant_a    = grant_a_q;
  assign grant_b    = grant_b_q;
  assign tx_start   = tx_start_q;
  assign rgmii_ctrl = rgmii_ctrl_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rgmii_tx_sched.sv
// Bench for rgmii_tx_sched: a framer model serves packets and checks grants and counts against a queue of predictions.
module tb_rgmii_tx_sched;

  localparam int IPG = 12;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ctrl;
  logic        req_a;
  logic        req_b;
  logic        tx_done;
  logic        grant_a;
  logic        grant_b;
  logic        tx_start;
  logic        rgmii_ctrl;
  logic [31:0] pkt_cnt;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  bit          exp_grant_q[$];
  logic [31:0] exp_cnt_q[$];
  bit          tb_last_b;
  logic [31:0] tb_cnt;

  always #5 clk = ~clk;

  rgmii_tx_sched #(
    .IPG_CYCLES(IPG),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctrl(ctrl),
    .req_a(req_a),
    .req_b(req_b),
    .tx_done(tx_done),
    .grant_a(grant_a),
    .grant_b(grant_b),
    .tx_start(tx_start),
    .rgmii_ctrl(rgmii_ctrl),
    .pkt_cnt(pkt_cnt),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  // Round-robin reference: ties go to the channel not granted last.
  task automatic expect_pkt(input bit ra, input bit rb, input bit clr);
    bit pa;
    pa = ra && (!rb || tb_last_b);
    tb_last_b = !pa;
    tb_cnt = clr ? 32'd0 : tb_cnt + 32'd1;
    exp_grant_q.push_back(pa);
    exp_cnt_q.push_back(tb_cnt);
  endtask

  task automatic serve_packet(input int lat, input bit early_done, input bit gap_done,
                              input bit clr_at_done, input bit drop_run);
    bit          got;
    bit          exp_a;
    logic [31:0] exp_cnt;
    int          gap;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL start_wait: tx_start not seen in 200 cycles, required one pulse");
      return;
    end
    exp_a   = exp_grant_q.pop_front();
    exp_cnt = exp_cnt_q.pop_front();
    if ({grant_a, grant_b} !== {exp_a, !exp_a}) begin
      errors++;
      $display("FAIL grant_at_start: grant_a/b=%b%b required %b%b", grant_a, grant_b, exp_a, !exp_a);
    end
    if (early_done) tx_done = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      tx_done = 1'b0;
      checks++;
      if ({grant_a, grant_b, busy, tx_start} !== {exp_a, !exp_a, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL grant_hold: cycle %0d grant_a/b,busy,tx_start=%b%b%b%b required %b%b10",
                 i, grant_a, grant_b, busy, tx_start, exp_a, !exp_a);
      end
      if (drop_run && i == 1) ctrl[0] = 1'b0;
      if (clr_at_done && i == lat - 1) ctrl[2] = 1'b1;
      if (i == lat) begin
        tx_done = 1'b1;
        ctrl[2] = 1'b0;
      end
    end
    @(negedge clk);
    tx_done = 1'b0;
    checks++;
    if ({grant_a, grant_b, busy} !== 3'b001 || pkt_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL pkt_end: grant_a/b,busy=%b%b%b pkt_cnt=%h required 001 pkt_cnt=%h",
               grant_a, grant_b, busy, pkt_cnt, exp_cnt);
    end
    gap = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      tx_done = 1'b0;
      checks++;
      if (tx_start !== 1'b0) begin
        errors++;
        $display("FAIL gap_start: tx_start=%b during gap cycle %0d, required 0", tx_start, gap);
      end
      if (busy !== 1'b1) break;
      gap++;
      if (gap_done && gap == 3) tx_done = 1'b1;
    end
    checks++;
    if (gap != IPG || pkt_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL gap_len: gap=%0d pkt_cnt=%h required gap=%0d pkt_cnt=%h", gap, pkt_cnt, IPG, exp_cnt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ctrl = 16'h0001; req_a = 1'b1; req_b = 1'b1; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({grant_a, grant_b, tx_start, rgmii_ctrl, busy, timeout_err} !== 6'b0 || pkt_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset: ga,gb,ts,rc,busy,te=%b%b%b%b%b%b pkt_cnt=%h required all 0",
               grant_a, grant_b, tx_start, rgmii_ctrl, busy, timeout_err, pkt_cnt);
    end
    rst = 1'b0; ctrl = 16'h0000; req_a = 1'b0; req_b = 1'b0;
    tb_last_b = 1'b1;
    tb_cnt = 32'd0;
  endtask

  task automatic test_round_robin;
    req_a = 1'b1; req_b = 1'b1; ctrl = 16'h0001;
    @(negedge clk);
    checks++;
    if (rgmii_ctrl !== 1'b0) begin
      errors++;
      $display("FAIL rgmii_rise_early: rgmii_ctrl=%b required 0", rgmii_ctrl);
    end
    @(negedge clk);
    checks++;
    if (rgmii_ctrl !== 1'b1) begin
      errors++;
      $display("FAIL rgmii_rise: rgmii_ctrl=%b required 1", rgmii_ctrl);
    end
    for (int p = 0; p < 4; p++) expect_pkt(1'b1, 1'b1, 1'b0);
    serve_packet(20, 1'b1, 1'b0, 1'b0, 1'b0);
    serve_packet(20, 1'b0, 1'b1, 1'b0, 1'b0);
    serve_packet(20, 1'b0, 1'b0, 1'b0, 1'b0);
    serve_packet(20, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stop_in_busy;
    int starts;
    expect_pkt(1'b1, 1'b1, 1'b0);
    serve_packet(20, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (rgmii_ctrl !== 1'b1) begin
      errors++;
      $display("FAIL rgmii_idle_entry: rgmii_ctrl=%b required 1", rgmii_ctrl);
    end
    @(negedge clk);
    checks++;
    if (rgmii_ctrl !== 1'b0) begin
      errors++;
      $display("FAIL rgmii_fall: rgmii_ctrl=%b required 0", rgmii_ctrl);
    end
    starts = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_start === 1'b1 || busy === 1'b1) starts++;
    end
    checks++;
    if (starts != 0) begin
      errors++;
      $display("FAIL stop_quiet: %0d active cycles after stop, required 0", starts);
    end
  endtask

  task automatic test_no_latch;
    int active;
    req_a = 1'b1; req_b = 1'b0;
    repeat (2) @(negedge clk);
    req_a = 1'b0;
    ctrl = 16'h0001;
    active = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_start === 1'b1 || busy === 1'b1) active++;
    end
    checks++;
    if (active != 0 || rgmii_ctrl !== 1'b1) begin
      errors++;
      $display("FAIL no_latch: active=%0d rgmii_ctrl=%b required 0 and 1", active, rgmii_ctrl);
    end
    ctrl = 16'h0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_burst;
    int active;
    req_a = 1'b1; req_b = 1'b0;
    for (int round = 0; round < 2; round++) begin
      ctrl = 16'h0303;
      for (int p = 0; p < 3; p++) expect_pkt(1'b1, 1'b0, 1'b0);
      for (int p = 0; p < 3; p++) serve_packet(4, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      active = 0;
      repeat (30) begin
        @(negedge clk);
        if (tx_start === 1'b1 || busy === 1'b1) active++;
      end
      checks++;
      if (active != 0 || rgmii_ctrl !== 1'b0) begin
        errors++;
        $display("FAIL burst_stop: round %0d active=%0d rgmii_ctrl=%b required 0 and 0", round, active, rgmii_ctrl);
      end
      ctrl = 16'h0302;
      repeat (3) @(negedge clk);
    end
    ctrl = 16'h0000;
  endtask

  task automatic test_clear_race;
    ctrl = 16'h0004;
    @(negedge clk);
    ctrl = 16'h0000;
    @(negedge clk);
    checks++;
    if (pkt_cnt !== 32'd0) begin
      errors++;
      $display("FAIL clear_idle: pkt_cnt=%h required 0", pkt_cnt);
    end
    tb_cnt = 32'd0;
    req_a = 1'b1; req_b = 1'b1; ctrl = 16'h0001;
    for (int p = 0; p < 5; p++) expect_pkt(1'b1, 1'b1, 1'b0);
    for (int p = 0; p < 5; p++) serve_packet(3, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_pkt(1'b1, 1'b1, 1'b1);
    serve_packet(4, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap;
    ctrl = 16'h0000; req_a = 1'b0; req_b = 1'b0;
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    release dut.pkt_cnt_q;
    @(negedge clk);
    checks++;
    if (pkt_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_preset: pkt_cnt=%h required ffffffff", pkt_cnt);
    end
    tb_cnt = 32'hFFFF_FFFF;
    req_a = 1'b1; ctrl = 16'h0001;
    expect_pkt(1'b1, 1'b0, 1'b0);
    expect_pkt(1'b1, 1'b0, 1'b0);
    serve_packet(5, 1'b0, 1'b0, 1'b0, 1'b0);
    serve_packet(5, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_busy_limit_and_reset;
    bit got;
    int n;
    req_a = 1'b0; req_b = 1'b1; ctrl = 16'h0001;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || grant_b !== 1'b1) begin
      errors++;
      $display("FAIL hold_start: seen=%b grant_b=%b required 1 and 1", got, grant_b);
    end
`ifdef TX_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (grant_b !== 1'b1) break;
      n++;
    end
    checks++;
    if (n != TMO || timeout_err !== 1'b1 || pkt_cnt !== tb_cnt) begin
      errors++;
      $display("FAIL timeout: busy_cycles=%0d timeout_err=%b pkt_cnt=%h required %0d 1 %h",
               n, timeout_err, pkt_cnt, TMO, tb_cnt);
    end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL restart_after_timeout: tx_start not seen, required one pulse");
    end
`else
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (grant_b === 1'b1 && busy === 1'b1) n++;
    end
    checks++;
    if (n != 300 || timeout_err !== 1'b0 || pkt_cnt !== tb_cnt) begin
      errors++;
      $display("FAIL busy_hold: held_cycles=%0d timeout_err=%b pkt_cnt=%h required 300 0 %h",
               n, timeout_err, pkt_cnt, tb_cnt);
    end
`endif
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({grant_a, grant_b, tx_start, rgmii_ctrl, busy, timeout_err} !== 6'b0 || pkt_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_busy: ga,gb,ts,rc,busy,te=%b%b%b%b%b%b pkt_cnt=%h required all 0",
               grant_a, grant_b, tx_start, rgmii_ctrl, busy, timeout_err, pkt_cnt);
    end
    ctrl = 16'h0000; req_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_start, busy, rgmii_ctrl} !== 3'b000 || pkt_cnt !== 32'd0) begin
      errors++;
      $display("FAIL post_reset: ts,busy,rc=%b%b%b pkt_cnt=%h required 000 and 0",
               tx_start, busy, rgmii_ctrl, pkt_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stop_in_busy();
    test_no_latch();
    test_burst();
    test_clear_race();
    test_wrap();
    test_busy_limit_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
